// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and the reorder-buffer bank state type.
package fft_pkg;

    localparam int FFT_L = 9;
    localparam int FFT_W = 32;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A bank may be written while it has not yet captured a complete frame.
    function automatic logic bankAcceptsWrite(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic bankHoldsFrame(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/bitrev_addr.sv
// Combinational L-bit index reversal: bit b of the result is bit L-1-b of the index.
module bitrev_addr #(
    parameter int L = 9
) (
    input  logic [L-1:0] i_idx,
    output logic [L-1:0] o_rev
);

    for (genvar b = 0; b < L; b++) begin : g_rev
        assign o_rev[b] = i_idx[L-1-b];
    end

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong frame reorder buffer: fills one bank while draining the other, replaying
// each frame in bit-reversed or natural order. Optional out_last port: BITREV_OUT_LAST_EN.
module bitrev_reorder_buf
    import fft_pkg::*;
#(
    parameter int L = FFT_L,
    parameter int W = FFT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         reverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef BITREV_OUT_LAST_EN
    ,
    output logic         out_last
`endif
);

    localparam int          N        = 1 << L;
    localparam logic [L-1:0] IDX_LAST = '1;

    bank_state_t  r_bankState     [2];
    bank_state_t  w_bankStateNext [2];
    logic [1:0]   r_bankRev;
    logic [1:0]   w_bankRevNext;

    logic         r_wrBank;
    logic [L-1:0] r_wrIdx;
    logic         r_rdBank;
    logic [L-1:0] r_rdIdx;

    logic [W-1:0] r_mem [2*N];

    logic         r_outValid;
    logic [W-1:0] r_outData;

    logic         w_wrFire;
    logic         w_load;
    logic [L-1:0] w_rdRev;
    logic [L-1:0] w_rdAddr;

    // in_ready depends only on registered bank state, never on out_ready.
    assign in_ready = bankAcceptsWrite(r_bankState[r_wrBank]);
    assign w_wrFire = in_valid && in_ready;
    assign w_load   = (!r_outValid || out_ready) && bankHoldsFrame(r_bankState[r_rdBank]);

    bitrev_addr #(
        .L (L)
    ) u_rdRev (
        .i_idx (r_rdIdx),
        .o_rev (w_rdRev)
    );

    assign w_rdAddr = r_bankRev[r_rdBank] ? w_rdRev : r_rdIdx;

    // Write and read never touch the same bank in one cycle: their legal states are disjoint.
    always_comb begin
        w_bankStateNext[0] = r_bankState[0];
        w_bankStateNext[1] = r_bankState[1];
        w_bankRevNext      = r_bankRev;

        if (w_wrFire) begin
            if (r_wrIdx == '0) begin
                w_bankStateNext[r_wrBank] = FILLING;
                w_bankRevNext[r_wrBank]   = reverse;
            end
            if (r_wrIdx == IDX_LAST) begin
                w_bankStateNext[r_wrBank] = FULL;
            end
        end

        if (w_load) begin
            if (r_rdIdx == IDX_LAST) begin
                w_bankStateNext[r_rdBank] = EMPTY;
            end else begin
                w_bankStateNext[r_rdBank] = DRAINING;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bankState[0] <= EMPTY;
            r_bankState[1] <= EMPTY;
            r_bankRev      <= '0;
        end else begin
            r_bankState[0] <= w_bankStateNext[0];
            r_bankState[1] <= w_bankStateNext[1];
            r_bankRev      <= w_bankRevNext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrBank <= 1'b0;
            r_wrIdx  <= '0;
        end else if (w_wrFire) begin
            r_wrIdx <= r_wrIdx + L'(1);
            if (r_wrIdx == IDX_LAST) begin
                r_wrBank <= ~r_wrBank;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdBank <= 1'b0;
            r_rdIdx  <= '0;
        end else if (w_load) begin
            r_rdIdx <= r_rdIdx + L'(1);
            if (r_rdIdx == IDX_LAST) begin
                r_rdBank <= ~r_rdBank;
            end
        end
    end

    // Sample storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wrFire) begin
            r_mem[{r_wrBank, r_wrIdx}] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outData  <= r_mem[{r_rdBank, w_rdAddr}];
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;

`ifdef BITREV_OUT_LAST_EN
    logic r_outLast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outLast <= 1'b0;
        end else if (w_load) begin
            r_outLast <= (r_rdIdx == IDX_LAST);
        end
    end

    assign out_last = r_outLast;
`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Self-checking bench for bitrev_reorder_buf (L=3): queue-based frame model plus literal pins.
module tb_bitrev_reorder_buf;

    localparam int L = 3;
    localparam int N = 8;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         reverse = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef BITREV_OUT_LAST_EN
    logic         out_last;
`endif

    int checks = 0;
    int passes = 0;

    typedef struct packed {logic rev; logic [W-1:0] data;} stim_t;
    typedef struct packed {logic last; logic [W-1:0] data;} word_t;

    stim_t        stimQ[$];
    word_t        availQ[$];
    logic [W-1:0] xferLog[$];
    logic         lastLog[$];
    logic [W-1:0] expQ[$];

    int           validPct = 100;
    int           readyPct = 100;
    int           brPerm[N];

    int           mWrIdx;
    logic         mCurRev;
    logic [W-1:0] mFrame[N];
    int           mPending;
    int           mAccepted = 0;
    logic         mInReady;
    logic         mOutValid;
    logic [W-1:0] mOutData;
    logic         mOutLast;

    bitrev_reorder_buf #(
        .L (L),
        .W (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .reverse   (reverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BITREV_OUT_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int revIdx(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < L; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic resetModel();
        mWrIdx    = 0;
        mCurRev   = 1'b0;
        mPending  = 0;
        mInReady  = 1'b1;
        mOutValid = 1'b0;
        mOutData  = '0;
        mOutLast  = 1'b0;
        availQ.delete();
        stimQ.delete();
        xferLog.delete();
        lastLog.delete();
        expQ.delete();
    endtask

    // Frame-level model: complete frames become a queue of words in replay order,
    // drained through a single output register with the valid/ready hold rule.
    always @(posedge clk) begin : model
        bit    acc;
        bit    ld;
        word_t w;
        stim_t s;
        if (reset_n) begin
            acc = in_valid && mInReady;
            ld  = (!mOutValid || out_ready) && (availQ.size() > 0);
            if (mOutValid && out_ready) begin
                xferLog.push_back(mOutData);
                lastLog.push_back(mOutLast);
            end
            if (ld) begin
                w = availQ.pop_front();
                mOutValid = 1'b1;
                mOutData  = w.data;
                mOutLast  = w.last;
                if (w.last) mPending--;
            end else if (out_ready) begin
                mOutValid = 1'b0;
            end
            if (acc) begin
                s = stimQ.pop_front();
                if (mWrIdx == 0) mCurRev = reverse;
                mFrame[mWrIdx] = in_data;
                mAccepted++;
                if (mWrIdx == N - 1) begin
                    for (int k = 0; k < N; k++) begin
                        w.data = mFrame[mCurRev ? revIdx(k) : k];
                        w.last = (k == N - 1);
                        availQ.push_back(w);
                    end
                    mPending++;
                    mWrIdx = 0;
                end else begin
                    mWrIdx++;
                end
            end
            mInReady = (mPending < 2);
        end
    end

    always @(negedge clk) begin : driver
        in_valid  = (stimQ.size() > 0) && ($urandom_range(99) < validPct);
        if (stimQ.size() > 0) begin
            in_data = stimQ[0].data;
            reverse = stimQ[0].rev;
        end
        out_ready = ($urandom_range(99) < readyPct);
    end

    always @(negedge clk) begin : compare
        if (reset_n) begin
            checkOutput("in_ready", in_ready, mInReady);
            checkOutput("out_valid", out_valid, mOutValid);
            if (mOutValid) checkOutput("out_data", out_data, mOutData);
`ifdef BITREV_OUT_LAST_EN
            if (mOutValid) checkOutput("out_last", out_last, mOutLast);
`endif
        end
    end

    // Queue one frame; only the first sample's reverse bit matters, the rest are noise.
    task automatic applyStimulus(input int base, input logic rev, input bit randData);
        stim_t s;
        logic [W-1:0] vals[N];
        for (int i = 0; i < N; i++) begin
            vals[i] = randData ? $urandom : base + i;
            s.data  = vals[i];
            s.rev   = (i == 0) ? rev : 1'($urandom_range(1));
            stimQ.push_back(s);
        end
        for (int i = 0; i < N; i++) expQ.push_back(vals[rev ? brPerm[i] : i]);
    endtask

    task automatic waitDrain(input int budget);
        int k = 0;
        while ((stimQ.size() > 0 || availQ.size() > 0 || mOutValid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("drain_left", stimQ.size() + availQ.size(), 0);
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_count"}, xferLog.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < xferLog.size(); i++)
            checkOutput(name, xferLog[i], expQ[i]);
        xferLog.delete();
        lastLog.delete();
        expQ.delete();
    endtask

    initial begin
        int base;
        int k;
        int lat;
        brPerm = '{0, 4, 2, 6, 1, 5, 3, 7};
        resetModel();

        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_data", out_data, 0);
        reset_n = 1'b1;

        base = mAccepted;
        applyStimulus(0, 1'b1, 1'b0);
        k = 0;
        while (mAccepted - base < N && k < 100) begin
            @(negedge clk);
            k++;
        end
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t1_latency", lat, 2);
        waitDrain(200);
        checkLog("t1_bitrev");

        applyStimulus(10, 1'b0, 1'b0);
        waitDrain(200);
        checkLog("t2_natural");

        readyPct = 0;
        base = mAccepted;
        applyStimulus(20, 1'b1, 1'b0);
        applyStimulus(30, 1'b0, 1'b0);
        applyStimulus(40, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("t3_accepted", mAccepted - base, 16);
        checkOutput("t3_in_ready", in_ready, 0);
        readyPct = 100;
        waitDrain(400);
        checkLog("t3_backpressure");

        validPct = 70;
        readyPct = 50;
        for (int f = 0; f < 20; f++) applyStimulus(0, 1'($urandom_range(1)), 1'b1);
        waitDrain(5000);
`ifdef BITREV_OUT_LAST_EN
        k = 0;
        for (int i = 0; i < lastLog.size(); i++) begin
            if (lastLog[i]) k++;
            if (lastLog[i] != (i % N == N - 1)) checkOutput("t6_last_pos", i, -1);
        end
        checkOutput("t6_last_count", k, 20);
`endif
        checkLog("t4_random");

        validPct = 100;
        readyPct = 0;
        base = mAccepted;
        applyStimulus(60, 1'b0, 1'b0);
        applyStimulus(50, 1'b1, 1'b0);
        k = 0;
        while (mAccepted - base < 13 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("t5_pre_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        resetModel();
        #1;
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n  = 1'b1;
        readyPct = 100;
        applyStimulus(70, 1'b1, 1'b0);
        waitDrain(200);
        checkLog("t5_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
